// File: rtl/thermostat_ctrl.sv
// thermostat_ctrl
//
// Single-clock thermostat controller. Up/Down edit a setpoint (ChangedTemp)
// with press-and-hold auto-repeat, Set latches it as the target
// (DesiredTemp), and a heat/cool state machine with a hysteresis band drives
// the HVAC demand outputs. CurrentTemp is either a slew model driven by the
// heat/cool demand (SIM_PLANT=1) or a periodic sample of the sensor
// (SIM_PLANT=0). Slow-rate behaviour uses clock-enable ticks, not derived
// clocks.
//
// Ports:
//   clk          system clock
//   Reset        asynchronous, active-high reset
//   Up, Down     debounced setpoint buttons, synchronous to clk
//   Set          debounced button latching the setpoint as the target
//   Temperature  sensor reading (WIDTH bits, unsigned)
//   ChangedTemp  setpoint currently being edited
//   DesiredTemp  latched target temperature
//   CurrentTemp  modelled or sampled room temperature
//   Heat, Cool   HVAC demand, never both high
//   AtTarget     registered CurrentTemp == DesiredTemp (one cycle lag)

module thermostat_ctrl #(
   parameter int WIDTH     = 8,
   parameter int TMIN      = 0,
   parameter int TMAX      = 99,
   parameter int ADJ_DIV   = 10_000_000,
   parameter int SLEW_DIV  = 80_000_000,
   parameter int HYST      = 1,
   parameter int SIM_PLANT = 1
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             Up,
   input  logic             Down,
   input  logic             Set,
   input  logic [WIDTH-1:0] Temperature,
   output logic [WIDTH-1:0] ChangedTemp,
   output logic [WIDTH-1:0] DesiredTemp,
   output logic [WIDTH-1:0] CurrentTemp,
   output logic             Heat,
   output logic             Cool,
   output logic             AtTarget
);

   localparam int ADJ_W  = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
   localparam int SLEW_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
   localparam logic [ADJ_W-1:0]  ADJ_LAST  = ADJ_W'(ADJ_DIV - 1);
   localparam logic [SLEW_W-1:0] SLEW_LAST = SLEW_W'(SLEW_DIV - 1);
   localparam logic [WIDTH-1:0]  T_MIN     = WIDTH'(TMIN);
   localparam logic [WIDTH-1:0]  T_MAX     = WIDTH'(TMAX);
   localparam logic [WIDTH:0]    HYST_W    = (WIDTH + 1)'(HYST);

   typedef enum logic [1:0] {INIT, IDLE, HEAT, COOL} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  changed_q, changed_d;
   logic [WIDTH-1:0]  desired_q, desired_d;
   logic [WIDTH-1:0]  current_q, current_d;
   logic [ADJ_W-1:0]  adjCnt_q, adjCnt_d;
   logic [SLEW_W-1:0] slewCnt_q, slewCnt_d;
   logic              upPrev_q, downPrev_q, setPrev_q;
   logic              atTarget_q, atTarget_d;

   logic              adjTick, slewTick;
   logic              bothHeld, upRise, downRise, setRise;
   logic              stepUp, stepDown, editing;
   logic [WIDTH:0]    curW, desW;

   // Limit a raw reading to the legal range; <= / >= keep the tests
   // meaningful even when a bound sits at the edge of the word.
   function automatic logic [WIDTH-1:0] clampTemp(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] r;
      r = x;
      if (x <= T_MIN) r = T_MIN;
      if (x >= T_MAX) r = T_MAX;
      return r;
   endfunction

   // Button edges against last cycle's sample. Pressing both directions at
   // once freezes editing, including any edge that arrives while the other
   // button is held. A held button re-steps on every adjust tick; a fresh
   // edge steps at once and restarts the tick counter so repeats are spaced
   // a full period after the press.
   always_comb begin
      adjTick  = (adjCnt_q == ADJ_LAST);
      slewTick = (slewCnt_q == SLEW_LAST);
      bothHeld = Up & Down;
      upRise   = Up & ~upPrev_q;
      downRise = Down & ~downPrev_q;
      setRise  = Set & ~setPrev_q;
      editing  = (state_q != INIT);
      stepUp   = editing & ~bothHeld & Up & (upRise | adjTick);
      stepDown = editing & ~bothHeld & Down & (downRise | adjTick);
      curW     = {1'b0, current_q};
      desW     = {1'b0, desired_q};
   end

   // Free-running tick counters; a new button edge pulls the adjust count
   // back to zero.
   always_comb begin
      adjCnt_d  = adjTick ? '0 : adjCnt_q + ADJ_W'(1);
      slewCnt_d = slewTick ? '0 : slewCnt_q + SLEW_W'(1);
      if (editing && !bothHeld && (upRise || downRise)) adjCnt_d = '0;
   end

   // Temperature registers. INIT seeds all three from the sensor; afterwards
   // the setpoint follows the buttons, Set copies it to the target, and the
   // current temperature moves only on slew ticks.
   always_comb begin
      changed_d = changed_q;
      desired_d = desired_q;
      current_d = current_q;
      if (state_q == INIT) begin
         changed_d = clampTemp(Temperature);
         desired_d = clampTemp(Temperature);
         current_d = clampTemp(Temperature);
      end else begin
         if (stepUp) begin
            changed_d = (changed_q >= T_MAX) ? T_MAX : changed_q + WIDTH'(1);
         end else if (stepDown) begin
            changed_d = (changed_q <= T_MIN) ? T_MIN : changed_q - WIDTH'(1);
         end
         if (setRise) desired_d = changed_q;
         if (slewTick) begin
            if (SIM_PLANT != 0) begin
               if (state_q == HEAT) begin
                  current_d = (current_q >= T_MAX) ? T_MAX : current_q + WIDTH'(1);
               end else if (state_q == COOL) begin
                  current_d = (current_q <= T_MIN) ? T_MIN : current_q - WIDTH'(1);
               end
            end else begin
               current_d = clampTemp(Temperature);
            end
         end
      end
   end

   // Heat/cool decision. Entering a demand state requires leaving the
   // hysteresis band; leaving it only requires reaching the target, and
   // reversing direction always passes through IDLE. Sums are one bit wider
   // so the band cannot wrap near the top of the word.
   always_comb begin
      state_d    = state_q;
      atTarget_d = (state_q != INIT) && (current_q == desired_q);
      case (state_q)
         INIT: state_d = IDLE;
         IDLE: begin
            if (curW + HYST_W < desW) state_d = HEAT;
            else if (curW > desW + HYST_W) state_d = COOL;
         end
         HEAT: if (curW >= desW) state_d = IDLE;
         COOL: if (curW <= desW) state_d = IDLE;
         default: state_d = INIT;
      endcase
   end

   // State, counters and button history all clear on reset.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= INIT;
         changed_q  <= '0;
         desired_q  <= '0;
         current_q  <= '0;
         adjCnt_q   <= '0;
         slewCnt_q  <= '0;
         upPrev_q   <= 1'b0;
         downPrev_q <= 1'b0;
         setPrev_q  <= 1'b0;
         atTarget_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         changed_q  <= changed_d;
         desired_q  <= desired_d;
         current_q  <= current_d;
         adjCnt_q   <= adjCnt_d;
         slewCnt_q  <= slewCnt_d;
         upPrev_q   <= Up;
         downPrev_q <= Down;
         setPrev_q  <= Set;
         atTarget_q <= atTarget_d;
      end
   end

   assign ChangedTemp = changed_q;
   assign DesiredTemp = desired_q;
   assign CurrentTemp = current_q;
   assign Heat        = (state_q == HEAT);
   assign Cool        = (state_q == COOL);
   assign AtTarget    = atTarget_q;

endmodule

// File: tb/tb_thermostat_ctrl.sv
// Testbench for thermostat_ctrl. Instance A uses the full 0..99 range with
// the slew plant; instance B uses a 60..90 range and tracks the sensor.
// Inputs change on the falling edge, outputs are sampled on the falling edge.

module tb_thermostat_ctrl;

   logic       clk = 1'b0;
   logic       Reset;
   logic       upA, downA, setA, upB, downB, setB;
   logic [7:0] tempA, tempB;
   logic [7:0] changedA, desiredA, currentA, changedB, desiredB, currentB;
   logic       heatA, coolA, atA, heatB, coolB, atB;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   always #5 clk = ~clk;

   // Count rising edges so tick phases can be tracked by the bench.
   always @(posedge clk) cyc <= cyc + 1;

   thermostat_ctrl #(
      .WIDTH(8), .TMIN(0), .TMAX(99), .ADJ_DIV(4), .SLEW_DIV(8),
      .HYST(1), .SIM_PLANT(1)
   ) dutA (
      .clk(clk), .Reset(Reset), .Up(upA), .Down(downA), .Set(setA),
      .Temperature(tempA), .ChangedTemp(changedA), .DesiredTemp(desiredA),
      .CurrentTemp(currentA), .Heat(heatA), .Cool(coolA), .AtTarget(atA)
   );

   thermostat_ctrl #(
      .WIDTH(8), .TMIN(60), .TMAX(90), .ADJ_DIV(4), .SLEW_DIV(8),
      .HYST(1), .SIM_PLANT(0)
   ) dutB (
      .clk(clk), .Reset(Reset), .Up(upB), .Down(downB), .Set(setB),
      .Temperature(tempB), .ChangedTemp(changedB), .DesiredTemp(desiredB),
      .CurrentTemp(currentB), .Heat(heatB), .Cool(coolB), .AtTarget(atB)
   );

   // Press-and-release n times on instance A (2 cycles per press).
   task automatic applyStimulusPressA(input logic goUp, input int n);
      for (int i = 0; i < n; i++) begin
         if (goUp) upA = 1'b1; else downA = 1'b1;
         @(negedge clk);
         upA = 1'b0; downA = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic applyStimulusPressB(input logic goUp, input int n);
      for (int i = 0; i < n; i++) begin
         if (goUp) upB = 1'b1; else downB = 1'b1;
         @(negedge clk);
         upB = 1'b0; downB = 1'b0;
         @(negedge clk);
      end
   endtask

   // One-cycle Set pulse; returns at the falling edge after it is sampled.
   task automatic applyStimulusSetA();
      setA = 1'b1;
      @(negedge clk);
      setA = 1'b0;
   endtask

   task automatic applyStimulusSetB();
      setB = 1'b1;
      @(negedge clk);
      setB = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      upA = 0; downA = 0; setA = 0; upB = 0; downB = 0; setB = 0;
      tempA = 8'd70; tempB = 8'd120;
      repeat (3) @(negedge clk);
      checks++;
      if ({changedA, desiredA, currentA, heatA, coolA, atA} !== 27'd0) begin
         errors++;
         $display("[TB] FAIL resetA: got %h expected 0", {changedA, desiredA, currentA, heatA, coolA, atA});
      end
      checks++;
      if ({changedB, desiredB, currentB, heatB, coolB, atB} !== 27'd0) begin
         errors++;
         $display("[TB] FAIL resetB: got %h expected 0", {changedB, desiredB, currentB, heatB, coolB, atB});
      end
      Reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({changedA, desiredA, currentA} !== {8'd70, 8'd70, 8'd70}) begin
         errors++;
         $display("[TB] FAIL initA: got %0d/%0d/%0d expected 70/70/70", changedA, desiredA, currentA);
      end
      checks++;
      if ({heatA, coolA, atA} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL initFlagsA: got %b expected 000", {heatA, coolA, atA});
      end
      checks++;
      if ({changedB, desiredB, currentB} !== {8'd90, 8'd90, 8'd90}) begin
         errors++;
         $display("[TB] FAIL initClampB: got %0d/%0d/%0d expected 90/90/90", changedB, desiredB, currentB);
      end
      @(negedge clk);
      checks++;
      if ({atA, atB, heatA, coolA} !== 4'b1100) begin
         errors++;
         $display("[TB] FAIL atTargetInit: got %b expected 1100", {atA, atB, heatA, coolA});
      end
   endtask

   task automatic test_auto_repeat();
      logic [7:0] exp;
      applyStimulusPressA(1'b1, 27);
      checks++;
      if (changedA !== 8'd97) begin
         errors++;
         $display("[TB] FAIL editTo97: got %0d expected 97", changedA);
      end
      upA = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         exp = (k < 4) ? 8'd98 : 8'd99;
         checks++;
         if (changedA !== exp) begin
            errors++;
            $display("[TB] FAIL holdUp cycle %0d: got %0d expected %0d", k, changedA, exp);
         end
      end
      downA = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checks++;
         if (changedA !== 8'd99) begin
            errors++;
            $display("[TB] FAIL upDownTogether cycle %0d: got %0d expected 99", k, changedA);
         end
      end
      upA = 1'b0; downA = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_heat_hysteresis();
      logic [7:0] prev;
      int n;
      applyStimulusPressA(1'b0, 28);
      checks++;
      if (changedA !== 8'd71) begin
         errors++;
         $display("[TB] FAIL editTo71: got %0d expected 71", changedA);
      end
      applyStimulusSetA();
      checks++;
      if (desiredA !== 8'd71) begin
         errors++;
         $display("[TB] FAIL set71: got %0d expected 71", desiredA);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (heatA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hystNoHeat cycle %0d: got %b expected 0", k, heatA);
         end
      end
      applyStimulusPressA(1'b1, 2);
      applyStimulusSetA();
      checks++;
      if ({desiredA, heatA} !== {8'd73, 1'b0}) begin
         errors++;
         $display("[TB] FAIL set73: got %0d heat %b expected 73 heat 0", desiredA, heatA);
      end
      @(negedge clk);
      checks++;
      if ({heatA, coolA, currentA} !== {2'b10, 8'd70}) begin
         errors++;
         $display("[TB] FAIL heatOn: got heat %b cool %b cur %0d expected 1 0 70", heatA, coolA, currentA);
      end
      prev = 8'd70;
      for (int s = 0; s < 3; s++) begin
         n = 0;
         while (currentA === prev && n < 20) begin
            @(negedge clk);
            n++;
         end
         checks++;
         if (currentA !== prev + 8'd1) begin
            errors++;
            $display("[TB] FAIL heatStep %0d: got %0d expected %0d", s, currentA, prev + 8'd1);
         end
         if (s > 0) begin
            checks++;
            if (n !== 8) begin
               errors++;
               $display("[TB] FAIL slewInterval %0d: got %0d expected 8", s, n);
            end
         end
         prev = prev + 8'd1;
      end
      checks++;
      if ({heatA, atA} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL reach73: got heat %b at %b expected 1 0", heatA, atA);
      end
      @(negedge clk);
      checks++;
      if ({heatA, coolA, atA} !== 3'b001) begin
         errors++;
         $display("[TB] FAIL heatOff: got %b expected 001", {heatA, coolA, atA});
      end
   endtask

   task automatic test_cool_retarget();
      int n;
      int tTick;
      logic bothSeen;
      bothSeen = 1'b0;
      applyStimulusPressA(1'b1, 7);
      applyStimulusSetA();
      checks++;
      if (desiredA !== 8'd80) begin
         errors++;
         $display("[TB] FAIL set80: got %0d expected 80", desiredA);
      end
      n = 0;
      while (currentA !== 8'd80 && n < 80) begin
         @(negedge clk);
         n++;
         if (heatA && coolA) bothSeen = 1'b1;
      end
      tTick = cyc;
      checks++;
      if (currentA !== 8'd80) begin
         errors++;
         $display("[TB] FAIL heatTo80: got %0d expected 80", currentA);
      end
      applyStimulusPressA(1'b0, 5);
      checks++;
      if ({changedA, currentA, heatA} !== {8'd75, 8'd80, 1'b0}) begin
         errors++;
         $display("[TB] FAIL idleAt80: got chg %0d cur %0d heat %b expected 75 80 0", changedA, currentA, heatA);
      end
      // Align Set one cycle after a slew tick so the retarget lands at 78.
      while (((cyc - tTick) % 8) != 0) @(negedge clk);
      applyStimulusSetA();
      checks++;
      if ({desiredA, coolA} !== {8'd75, 1'b0}) begin
         errors++;
         $display("[TB] FAIL set75: got %0d cool %b expected 75 cool 0", desiredA, coolA);
      end
      @(negedge clk);
      checks++;
      if ({coolA, heatA} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL coolOn: got cool %b heat %b expected 1 0", coolA, heatA);
      end
      for (int i = 0; i < 10; i++) begin
         upA = 1'b1;
         @(negedge clk);
         if (heatA && coolA) bothSeen = 1'b1;
         upA = 1'b0;
         @(negedge clk);
         if (heatA && coolA) bothSeen = 1'b1;
      end
      n = 0;
      while (currentA !== 8'd78 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if ({changedA, currentA} !== {8'd85, 8'd78}) begin
         errors++;
         $display("[TB] FAIL retargetPoint: got chg %0d cur %0d expected 85 78", changedA, currentA);
      end
      applyStimulusSetA();
      checks++;
      if ({desiredA, coolA} !== {8'd85, 1'b1}) begin
         errors++;
         $display("[TB] FAIL set85: got %0d cool %b expected 85 cool 1", desiredA, coolA);
      end
      @(negedge clk);
      checks++;
      if ({coolA, heatA} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL viaIdle: got cool %b heat %b expected 0 0", coolA, heatA);
      end
      @(negedge clk);
      checks++;
      if ({coolA, heatA} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL heatAfterIdle: got cool %b heat %b expected 0 1", coolA, heatA);
      end
      checks++;
      if (bothSeen !== 1'b0) begin
         errors++;
         $display("[TB] FAIL neverBoth: got %b expected 0", bothSeen);
      end
   endtask

   task automatic test_clamp();
      applyStimulusPressB(1'b1, 1);
      checks++;
      if (changedB !== 8'd90) begin
         errors++;
         $display("[TB] FAIL upAtMax: got %0d expected 90", changedB);
      end
      applyStimulusPressB(1'b0, 30);
      checks++;
      if (changedB !== 8'd60) begin
         errors++;
         $display("[TB] FAIL downTo60: got %0d expected 60", changedB);
      end
      applyStimulusPressB(1'b0, 1);
      checks++;
      if (changedB !== 8'd60) begin
         errors++;
         $display("[TB] FAIL downAtMin: got %0d expected 60", changedB);
      end
   endtask

   task automatic test_sensor();
      int n;
      tempB = 8'd70;
      n = 0;
      while (currentB === 8'd90 && n < 12) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (currentB !== 8'd70) begin
         errors++;
         $display("[TB] FAIL sample70: got %0d expected 70", currentB);
      end
      @(negedge clk);
      checks++;
      if ({heatB, coolB} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL sensorHeat: got heat %b cool %b expected 1 0", heatB, coolB);
      end
      tempB = 8'd74;
      n = 0;
      while (currentB === 8'd70 && n < 12) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if ({currentB, heatB} !== {8'd74, 1'b1}) begin
         errors++;
         $display("[TB] FAIL sample74: got %0d heat %b expected 74 heat 1", currentB, heatB);
      end
      applyStimulusPressB(1'b1, 15);
      applyStimulusSetB();
      @(negedge clk);
      checks++;
      if ({desiredB, heatB} !== {8'd75, 1'b1}) begin
         errors++;
         $display("[TB] FAIL hold75: got %0d heat %b expected 75 heat 1", desiredB, heatB);
      end
      applyStimulusPressB(1'b0, 1);
      applyStimulusSetB();
      @(negedge clk);
      checks++;
      if ({desiredB, heatB} !== {8'd74, 1'b0}) begin
         errors++;
         $display("[TB] FAIL reached74: got %0d heat %b expected 74 heat 0", desiredB, heatB);
      end
      applyStimulusPressB(1'b1, 1);
      applyStimulusSetB();
      @(negedge clk);
      checks++;
      if ({desiredB, heatB} !== {8'd75, 1'b0}) begin
         errors++;
         $display("[TB] FAIL band75: got %0d heat %b expected 75 heat 0", desiredB, heatB);
      end
      applyStimulusPressB(1'b1, 1);
      applyStimulusSetB();
      checks++;
      if ({desiredB, heatB} !== {8'd76, 1'b0}) begin
         errors++;
         $display("[TB] FAIL set76: got %0d heat %b expected 76 heat 0", desiredB, heatB);
      end
      @(negedge clk);
      checks++;
      if ({heatB, coolB} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL heat76: got heat %b cool %b expected 1 0", heatB, coolB);
      end
      tempB = 8'd95;
      n = 0;
      while (currentB === 8'd74 && n < 12) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if ({currentB, heatB} !== {8'd90, 1'b1}) begin
         errors++;
         $display("[TB] FAIL sampleClamp: got %0d heat %b expected 90 heat 1", currentB, heatB);
      end
      @(negedge clk);
      checks++;
      if ({heatB, coolB} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL sensorIdle: got heat %b cool %b expected 0 0", heatB, coolB);
      end
      @(negedge clk);
      checks++;
      if ({heatB, coolB} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL sensorCool: got heat %b cool %b expected 0 1", heatB, coolB);
      end
   endtask

   task automatic test_mid_reset();
      #2;
      Reset = 1'b1;
      tempA = 8'd65;
      tempB = 8'd74;
      #1;
      checks++;
      if ({changedA, desiredA, currentA, heatA, coolA, atA, heatB, coolB} !== 29'd0) begin
         errors++;
         $display("[TB] FAIL asyncReset: got %h expected 0", {changedA, desiredA, currentA, heatA, coolA, atA, heatB, coolB});
      end
      @(negedge clk);
      Reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({changedA, desiredA, currentA, atA} !== {8'd65, 8'd65, 8'd65, 1'b0}) begin
         errors++;
         $display("[TB] FAIL reinitA: got %0d/%0d/%0d at %b expected 65/65/65 at 0", changedA, desiredA, currentA, atA);
      end
      checks++;
      if ({changedB, desiredB, currentB} !== {8'd74, 8'd74, 8'd74}) begin
         errors++;
         $display("[TB] FAIL reinitB: got %0d/%0d/%0d expected 74/74/74", changedB, desiredB, currentB);
      end
      @(negedge clk);
      checks++;
      if ({atA, atB, heatA, coolA} !== 4'b1100) begin
         errors++;
         $display("[TB] FAIL reinitAt: got %b expected 1100", {atA, atB, heatA, coolA});
      end
   endtask

   initial begin
      $display("[TB] thermostat_ctrl bench start");
      test_reset();
      test_auto_repeat();
      test_heat_hysteresis();
      test_cool_retarget();
      test_clamp();
      test_sensor();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
